// File: rtl/regfile_wb_arbiter_if.sv
// Writeback request/grant bundle between the two writeback sources
// (ALU result path, load return path) and the register-file write port.
//
// Handshake: a source raises *_valid_in with stable rd/data and holds them
// until the matching *_ready_out is 1; the transfer happens on the rising
// clock edge where valid and ready are both 1. Ready is combinational from
// the valid inputs, the arbiter state and flush_in, and at most one ready is
// high per cycle.
interface regfile_wb_arbiter_if #(
    parameter int REG_DATA_WIDTH_POW = 6
);
    localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;

    logic                      flush_in;
    logic                      alu_valid_in;
    logic [4:0]                alu_rd_in;
    logic [REG_DATA_WIDTH-1:0] alu_data_in;
    logic                      alu_ready_out;
    logic                      mem_valid_in;
    logic [4:0]                mem_rd_in;
    logic [REG_DATA_WIDTH-1:0] mem_data_in;
    logic                      mem_ready_out;
    logic                      write_en_out;
    logic [4:0]                rd_out;
    logic [REG_DATA_WIDTH-1:0] write_data_out;
    logic                      grant_src_out;
    logic [3:0]                starve_cnt_out;
    logic                      state_out;      // 0 = PRIO_MEM, 1 = PRIO_ALU

    // Writeback sources / environment side.
    modport master (
        output flush_in,
        output alu_valid_in, alu_rd_in, alu_data_in,
        input  alu_ready_out,
        output mem_valid_in, mem_rd_in, mem_data_in,
        input  mem_ready_out,
        input  write_en_out, rd_out, write_data_out, grant_src_out,
        input  starve_cnt_out, state_out
    );

    // Arbiter side.
    modport slave (
        input  flush_in,
        input  alu_valid_in, alu_rd_in, alu_data_in,
        output alu_ready_out,
        input  mem_valid_in, mem_rd_in, mem_data_in,
        output mem_ready_out,
        output write_en_out, rd_out, write_data_out, grant_src_out,
        output starve_cnt_out, state_out
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: shares the single write port between the
// ALU and load paths. Loads win by default; an ALU request that has waited
// STARVE_LIMIT consecutive cycles gets priority for one grant. The write
// request to the register file is registered (latency 1) and writes to x0 are
// swallowed here so the register file never sees them.
module regfile_wb_arbiter #(
    parameter int REG_DATA_WIDTH_POW = 6,
    parameter int STARVE_LIMIT       = 4
) (
    input  logic                   clk_in,
    input  logic                   reset_n,
    regfile_wb_arbiter_if.slave    wb
);
    localparam int REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW;
    localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

    typedef enum logic {
        PRIO_MEM = 1'b0,
        PRIO_ALU = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0]                starve_q, starve_d;
    logic                      wen_q, wen_d;
    logic [4:0]                rd_q, rd_d;
    logic [REG_DATA_WIDTH-1:0] data_q, data_d;
    logic                      src_q, src_d;

    logic                      alu_grant;
    logic                      mem_grant;

    // Grant selection: priority follows the FSM state; flush and reset block everything.
    always_comb begin
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (reset_n && !wb.flush_in) begin
            if (state_q == PRIO_MEM) begin
                mem_grant = wb.mem_valid_in;
                alu_grant = wb.alu_valid_in && !wb.mem_valid_in;
            end else begin
                alu_grant = wb.alu_valid_in;
                mem_grant = wb.mem_valid_in && !wb.alu_valid_in;
            end
        end
    end

    // Starvation count and priority state; both freeze while flush is asserted.
    always_comb begin
        starve_d = starve_q;
        state_d  = state_q;
        if (!wb.flush_in) begin
            if (!wb.alu_valid_in || alu_grant) begin
                starve_d = 4'd0;
            end else if (starve_q != 4'hF) begin
                starve_d = starve_q + 4'd1;
            end

            case (state_q)
                PRIO_MEM: begin
                    if (starve_d >= STARVE_LIMIT_C) begin
                        state_d = PRIO_ALU;
                    end
                end
                PRIO_ALU: begin
                    if (alu_grant || !wb.alu_valid_in) begin
                        state_d = PRIO_MEM;
                    end
                end
                default: state_d = PRIO_MEM;
            endcase
        end
    end

    // Output stage next values: a granted non-x0 request is written next cycle,
    // otherwise the write enable drops and the index/data/source hold.
    always_comb begin
        wen_d  = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        src_d  = src_q;
        if (mem_grant && (wb.mem_rd_in != 5'd0)) begin
            wen_d  = 1'b1;
            rd_d   = wb.mem_rd_in;
            data_d = wb.mem_data_in;
            src_d  = 1'b1;
        end else if (alu_grant && (wb.alu_rd_in != 5'd0)) begin
            wen_d  = 1'b1;
            rd_d   = wb.alu_rd_in;
            data_d = wb.alu_data_in;
            src_d  = 1'b0;
        end
    end

    // State, counter and write-request registers; reset drops any pending write at once.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= PRIO_MEM;
            starve_q <= 4'd0;
            wen_q    <= 1'b0;
            rd_q     <= 5'd0;
            data_q   <= '0;
            src_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            wen_q    <= wen_d;
            rd_q     <= rd_d;
            data_q   <= data_d;
            src_q    <= src_d;
        end
    end

    assign wb.alu_ready_out  = alu_grant;
    assign wb.mem_ready_out  = mem_grant;
    assign wb.write_en_out   = wen_q;
    assign wb.rd_out         = rd_q;
    assign wb.write_data_out = data_q;
    assign wb.grant_src_out  = src_q;
    assign wb.starve_cnt_out = starve_q;
    assign wb.state_out      = state_q;
endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
Shares the single register-file write port between two writeback sources: the ALU result path and the load (MEM) return path. It arbitrates with valid/ready handshakes, uses fixed MEM priority with an ALU anti-starvation override, and drives a registered write request (write_en/rd/data) into the register file. x0 writes are absorbed here, so the register file never sees them.

Parameters:
REG_DATA_WIDTH_POW, 6, log2 of data width; REG_DATA_WIDTH = 1 << REG_DATA_WIDTH_POW (64).
STARVE_LIMIT, 4, consecutive ALU-valid-but-not-granted cycles before ALU gets forced priority; legal range 1..15.

Ports:
clk_in  input  1  clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
flush_in  input  1  synchronous flush; blocks all grants this cycle.
alu_valid_in  input  1  ALU writeback request.
alu_rd_in  input  5  ALU destination register.
alu_data_in  input  REG_DATA_WIDTH  ALU result.
alu_ready_out  output  1  ALU request granted this cycle.
mem_valid_in  input  1  load writeback request.
mem_rd_in  input  5  load destination register.
mem_data_in  input  REG_DATA_WIDTH  load data.
mem_ready_out  output  1  MEM request granted this cycle.
write_en_out  output  1  register-file write enable (registered).
rd_out  output  5  register-file write index (registered).
write_data_out  output  REG_DATA_WIDTH  register-file write data (registered).
grant_src_out  output  1  source of the current write_en_out: 0 = ALU, 1 = MEM (registered).
starve_cnt_out  output  4  current ALU starvation count, for debug.

Behaviour:
- Reset (reset_n low, asynchronous): write_en_out=0, rd_out=0, write_data_out=0, grant_src_out=0, starve_cnt_out=0, FSM=PRIO_MEM. alu_ready_out and mem_ready_out are 0 while reset_n is low.
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. The ready outputs are combinational from the valid inputs, the FSM state and flush_in. At most one ready is high per cycle. A source must hold valid/rd/data stable until ready.
- FSM states:
  - PRIO_MEM: if mem_valid_in, grant MEM; else if alu_valid_in, grant ALU.
  - PRIO_ALU: if alu_valid_in, grant ALU; else if mem_valid_in, grant MEM.
- Starvation counter:
  - Increments (saturating at 15) on each cycle where alu_valid_in=1, ALU is not granted and flush_in=0.
  - Clears to 0 on an ALU grant, or on any cycle with alu_valid_in=0.
  - Transition PRIO_MEM -> PRIO_ALU on the edge where the next counter value reaches STARVE_LIMIT.
  - Transition PRIO_ALU -> PRIO_MEM on the edge following an ALU grant, or when alu_valid_in drops.
- Output stage, latency 1:
  - On a grant, the next cycle presents write_en_out=1, rd_out=granted rd, write_data_out=granted data, grant_src_out=granted source.
  - With no grant, the next cycle presents write_en_out=0; rd_out, write_data_out and grant_src_out hold their previous values.
  - The register-file port never back-pressures, so the arbiter can grant one request every cycle.
- x0 absorption: a granted request with rd=0 completes its handshake (ready=1) but produces write_en_out=0 next cycle. It counts as a grant for starvation and FSM purposes.
- Same rd from both sources in one cycle: only the winner is written this cycle. The loser stays pending and is written in a later cycle, so the loser's value is the final register value.
- Flush:
  - flush_in=1 forces both readies to 0. Write_en_out is still driven next cycle from the previous grant, because the output stage is already committed.
  - The starvation counter holds and the FSM state holds.
- Reset mid-operation: a pending write_en_out is dropped immediately (asynchronous clear). No partial write is emitted after reset_n rises.

Test Plan:
- Reset sequence: assert reset_n=0 mid-cycle with write_en_out=1 -> write_en_out, rd_out, write_data_out and starve_cnt_out go to 0 immediately; after release, the FSM is PRIO_MEM.
- Single ALU request: alu_valid=1, rd=5, data=0xDEAD, mem idle -> alu_ready=1 same cycle; next cycle write_en_out=1, rd_out=5, write_data_out=0xDEAD, grant_src_out=0.
- Contention: both valid every cycle, STARVE_LIMIT=4 -> MEM granted for 4 cycles, starve_cnt_out counts 1..4, ALU granted on the 5th cycle, then MEM again.
- x0 write: mem_valid=1, rd=0, data=0xFFFF -> mem_ready=1; next cycle write_en_out=0; starve counter unaffected since ALU is idle.
- Same-rd collision: ALU rd=7 data=0x1 and MEM rd=7 data=0x2 in the same cycle -> write rd=7 data=0x2 (MEM), then the next cycle writes rd=7 data=0x1 (ALU).
- Flush: both valid with flush_in=1 for 2 cycles -> both readies 0, starve_cnt_out holds, write_en_out=0 from the second cycle; after flush_in drops, MEM is granted.
